// File: rtl/imem_loader.sv
// Byte-stream program loader: packs little-endian bytes into 32-bit words, writes them
// to instruction memory until the zero terminator, then releases the CPU reset.
// Optional checksum byte after the terminator: define IMEM_LOADER_CHECKSUM_EN.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | after reset, waiting for load_start_i
// COLLECT | accepting the four bytes of the current word
// WRITE   | one-cycle write of the packed word into instruction memory
// CHECK   | accepting the checksum byte (checksum build only)
// DONE    | terminator written (and checksum matched); CPU released
// ERR     | no terminator within capacity, or checksum mismatch
module imem_loader #(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_start_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_data_i,
  output logic              byte_ready_o,
  output logic              im_we_o,
  output logic [ADDR_W-1:0] im_addr_o,
  output logic [31:0]       im_wdata_o,
  output logic              cpu_rst_n_o,
  output logic [ADDR_W:0]   word_cnt_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_COLLECT, S_WRITE, S_CHECK, S_DONE, S_ERR
  } state_t;

  state_t      state, next_state;
  logic [1:0]  byte_cnt;
  logic [23:0] word_buf;
  logic        byte_acc;
  logic        start_ok;
  logic        last_slot;
  logic        byte_ready_d, im_we_d, cpu_rst_n_d, done_d, err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  assign byte_acc  = byte_valid_i & byte_ready_o;
  assign start_ok  = load_start_i &
                     ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));
  assign last_slot = (word_cnt_o == CNT_W'(MAX_WORDS - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:    if (start_ok) next_state = S_COLLECT;
      S_COLLECT: if (byte_acc && byte_cnt == 2'd3) next_state = S_WRITE;
      S_WRITE: begin
        if (im_wdata_o == 32'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          next_state = S_CHECK;
`else
          next_state = S_DONE;
`endif
        end else if (last_slot) begin
          next_state = S_ERR;
        end else begin
          next_state = S_COLLECT;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK:   if (byte_acc) next_state = (byte_data_i == csum) ? S_DONE : S_ERR;
`endif
      S_DONE,
      S_ERR:     if (start_ok) next_state = S_COLLECT;
      default:   next_state = S_IDLE;
    endcase
  end

  // Outputs are decoded from next_state and registered, so they switch with the state.
  always_comb begin
    byte_ready_d = (next_state == S_COLLECT) || (next_state == S_CHECK);
    im_we_d      = (next_state == S_WRITE);
    cpu_rst_n_d  = (next_state == S_DONE);
    done_d       = (next_state == S_DONE);
    err_d        = (next_state == S_ERR);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      byte_ready_o <= 1'b0;
      im_we_o      <= 1'b0;
      cpu_rst_n_o  <= 1'b0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      byte_ready_o <= byte_ready_d;
      im_we_o      <= im_we_d;
      cpu_rst_n_o  <= cpu_rst_n_d;
      done_o       <= done_d;
      err_o        <= err_d;
    end
  end

  // Bytes shift in from the top so byte 0 ends up in the least significant lane.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      byte_cnt   <= 2'd0;
      word_buf   <= 24'd0;
      im_addr_o  <= '0;
      im_wdata_o <= 32'd0;
      word_cnt_o <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum       <= 8'd0;
`endif
    end else if (start_ok) begin
      byte_cnt   <= 2'd0;
      im_addr_o  <= '0;
      word_cnt_o <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum       <= 8'd0;
`endif
    end else begin
      case (state)
        S_COLLECT: begin
          if (byte_acc) begin
            word_buf <= {byte_data_i, word_buf[23:8]};
            byte_cnt <= byte_cnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum     <= csum ^ byte_data_i;
`endif
            if (byte_cnt == 2'd3) im_wdata_o <= {byte_data_i, word_buf};
          end
        end
        S_WRITE: begin
          im_addr_o  <= im_addr_o + 1'b1;
          word_cnt_o <= word_cnt_o + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
